// File: rtl/if_packet_sender_pkg.sv
// Shared types and widths for the IF-stage packet sender: FSM states, packet record, lane widths.
package if_packet_sender_pkg;

  localparam int unsigned EXC_W  = 5;
  localparam int unsigned CKPT_W = 8;
  localparam int unsigned SLOTS  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DRAIN,
    S_HALT
  } if_state_e;

  typedef struct packed {
    logic [3:0]          enable;
    logic [127:0]        inst;
    logic [2:0]          num;
    logic [31:0]         base;
    logic                exc;
    logic [EXC_W-1:0]    code;
    logic                refill;
    logic [127:0]        dest;
    logic [3:0]          take;
    logic [4*CKPT_W-1:0] info;
  } if_pkt_t;

  function automatic logic [31:0] next_line_pc(input logic [27:0] line_idx);
    return {line_idx + 28'd1, 4'b0000};
  endfunction

endpackage

// File: rtl/if_packet_sender_align.sv
// if_pkt_align: rotates an I-cache line and its prediction lanes to the fetch PC,
// truncates after the first predicted-taken slot and picks the following fetch PC.
module if_pkt_align
  import if_packet_sender_pkg::*;
(
  input  logic [31:2]          pc_i,
  input  logic                 exc_i,
  input  logic [127:0]         line_i,
  input  logic [3:0]           take_i,
  input  logic [127:0]         dest_i,
  input  logic [4*CKPT_W-1:0]  info_i,
  output logic [127:0]         inst_p_o,
  output logic [3:0]           take_p_o,
  output logic [127:0]         dest_p_o,
  output logic [4*CKPT_W-1:0]  info_p_o,
  output logic [3:0]           enable_o,
  output logic [2:0]           num_o,
  output logic [31:0]          next_pc_o
);

  logic [31:0]       line_w [SLOTS];
  logic [31:0]       dest_w [SLOTS];
  logic [CKPT_W-1:0] info_w [SLOTS];
  logic [1:0]        off, word, k;
  logic [2:0]        n0, num;
  logic              found;

  always_comb begin
    for (int unsigned i = 0; i < SLOTS; i++) begin
      line_w[i] = line_i[32*i +: 32];
      dest_w[i] = dest_i[32*i +: 32];
      info_w[i] = info_i[CKPT_W*i +: CKPT_W];
    end
  end

  always_comb begin
    off      = pc_i[3:2];
    n0       = 3'd4 - {1'b0, off};
    found    = 1'b0;
    k        = '0;
    word     = '0;
    inst_p_o = '0;
    dest_p_o = '0;
    info_p_o = '0;
    take_p_o = '0;
    enable_o = '0;
    // Only words at or after the fetch offset exist in this packet.
    for (int unsigned i = 0; i < SLOTS; i++) begin
      if (3'(i) < n0) begin
        word = off + 2'(i);
        inst_p_o[32*i +: 32]         = line_w[word];
        dest_p_o[32*i +: 32]         = dest_w[word];
        info_p_o[CKPT_W*i +: CKPT_W] = info_w[word];
        if (!found && !exc_i && take_i[word]) begin
          found = 1'b1;
          k     = 2'(i);
        end
      end
    end
    num = exc_i ? 3'd1 : (found ? {1'b0, k} + 3'd1 : n0);
    if (found) take_p_o[k] = 1'b1;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      enable_o[i] = (3'(i) < num);
    end
    num_o     = num;
    next_pc_o = found ? dest_w[off + k] : next_line_pc(pc_i[31:4]);
  end

endmodule

// File: rtl/if_packet_sender.sv
// IF-stage producer: owns the fetch PC, requests I-cache lines and emits one aligned packet per line.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module if_packet_sender
  import if_packet_sender_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int unsigned PERF_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 SBA_flush_w_i,
  input  logic [31:0]          SBA_flushDest_i,
  input  logic                 CP0_excOccur_w_i,
  input  logic [31:0]          CP0_excDest_i,
  input  logic                 ID_stopFetch_i,
  output logic                 IC_req_o,
  output logic [31:0]          IC_addr_o,
  input  logic                 IC_ack_i,
  input  logic                 IC_rvalid_i,
  input  logic [127:0]         IC_line_i,
  input  logic                 IC_hasException_i,
  input  logic [EXC_W-1:0]     IC_ExcCode_i,
  input  logic                 IC_isRefill_i,
  input  logic [3:0]           BP_predTake_i,
  input  logic [127:0]         BP_predDest_i,
  input  logic [4*CKPT_W-1:0]  BP_predInfo_i,
  output logic                 IF_valid_o,
  output logic [3:0]           IF_instEnable_o,
  output logic [127:0]         IF_inst_p_o,
  output logic [2:0]           IF_instNum_o,
  output logic [31:0]          IF_instBasePC_o,
  output logic                 IF_hasException_o,
  output logic [EXC_W-1:0]     IF_ExcCode_o,
  output logic                 IF_isRefill_o,
  output logic [127:0]         IF_predDest_p_o,
  output logic [3:0]           IF_predTake_p_o,
  output logic [4*CKPT_W-1:0]  IF_predInfo_p_o,
  output logic [PERF_W-1:0]    IF_perfPkts_o,
  output logic [PERF_W-1:0]    IF_perfStall_o
);

  if_state_e           state_q, state_d;
  logic [31:0]         pc_q, pc_d;
  logic                valid_q, valid_d;
  if_pkt_t             pkt_q, pkt_d;
  logic                flush;
  logic [31:0]         flush_dest;
  logic [127:0]        al_inst, al_dest;
  logic [3:0]          al_take, al_en;
  logic [4*CKPT_W-1:0] al_info;
  logic [2:0]          al_num;
  logic [31:0]         al_next_pc;

  assign flush      = CP0_excOccur_w_i | SBA_flush_w_i;
  assign flush_dest = CP0_excOccur_w_i ? CP0_excDest_i : SBA_flushDest_i;

  if_pkt_align u_align (
    .pc_i      (pc_q[31:2]),
    .exc_i     (IC_hasException_i),
    .line_i    (IC_line_i),
    .take_i    (BP_predTake_i),
    .dest_i    (BP_predDest_i),
    .info_i    (BP_predInfo_i),
    .inst_p_o  (al_inst),
    .take_p_o  (al_take),
    .dest_p_o  (al_dest),
    .info_p_o  (al_info),
    .enable_o  (al_en),
    .num_o     (al_num),
    .next_pc_o (al_next_pc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      // A response already accepted by the I-cache must be swallowed before refetching.
      case (state_q)
        S_WAIT:  state_d = IC_rvalid_i ? S_REQ : S_DRAIN;
        S_REQ:   state_d = IC_ack_i ? S_DRAIN : S_REQ;
        S_DRAIN: state_d = IC_rvalid_i ? S_REQ : S_DRAIN;
        default: state_d = ID_stopFetch_i ? S_IDLE : S_REQ;
      endcase
    end else begin
      case (state_q)
        S_IDLE:  if (!ID_stopFetch_i) state_d = S_REQ;
        S_REQ:   if (IC_ack_i) state_d = S_WAIT;
        S_WAIT:  if (IC_rvalid_i) state_d = IC_hasException_i ? S_HALT :
                                            (ID_stopFetch_i ? S_IDLE : S_REQ);
        S_DRAIN: if (IC_rvalid_i) state_d = S_REQ;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    IC_req_o = (state_q == S_REQ);
    valid_d  = (state_q == S_WAIT) && IC_rvalid_i && !flush;
    pc_d     = pc_q;
    if (flush)                                pc_d = flush_dest;
    else if (valid_d && !IC_hasException_i)   pc_d = al_next_pc;
    pkt_d = pkt_q;
    if (valid_d) begin
      pkt_d.enable = al_en;
      pkt_d.inst   = al_inst;
      pkt_d.num    = al_num;
      pkt_d.base   = pc_q;
      pkt_d.exc    = IC_hasException_i;
      pkt_d.code   = IC_ExcCode_i;
      pkt_d.refill = IC_isRefill_i;
      pkt_d.dest   = al_dest;
      pkt_d.take   = al_take;
      pkt_d.info   = al_info;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      pkt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      pkt_q   <= pkt_d;
    end
  end

  assign IC_addr_o         = pc_q;
  assign IF_valid_o        = valid_q;
  assign IF_instEnable_o   = pkt_q.enable;
  assign IF_inst_p_o       = pkt_q.inst;
  assign IF_instNum_o      = pkt_q.num;
  assign IF_instBasePC_o   = pkt_q.base;
  assign IF_hasException_o = pkt_q.exc;
  assign IF_ExcCode_o      = pkt_q.code;
  assign IF_isRefill_o     = pkt_q.refill;
  assign IF_predDest_p_o   = pkt_q.dest;
  assign IF_predTake_p_o   = pkt_q.take;
  assign IF_predInfo_p_o   = pkt_q.info;

`ifdef IF_PERF_CNT_EN
  logic [PERF_W-1:0] perf_pkts_q, perf_pkts_d, perf_stall_q, perf_stall_d;

  always_comb begin
    perf_pkts_d  = perf_pkts_q + PERF_W'(valid_q);
    perf_stall_d = perf_stall_q + PERF_W'((state_q == S_IDLE) && ID_stopFetch_i);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_pkts_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_pkts_q  <= perf_pkts_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign IF_perfPkts_o  = perf_pkts_q;
  assign IF_perfStall_o = perf_stall_q;
`else
  assign IF_perfPkts_o  = '0;
  assign IF_perfStall_o = '0;
`endif

endmodule
